// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction phase counter and program-address sequencer (IDLE/RUN/HALT).
// Define PC_SEQ_AUTOHALT_EN to halt automatically after the instruction at LAST_ADDR.
module pc_sequencer #(
    parameter int SIZE_CNT  = 3,
    parameter int CNT_MAX   = 4,
    parameter int CNT_CLK   = 2,
    parameter int LAST_ADDR = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                halt_req,
    input  logic                stall,
    input  logic                jmp_en,
    input  logic [3:0]          jmp_addr,
    output logic [SIZE_CNT:0]   cnt_clk,
    output logic [3:0]          Data_Addr,
    output logic                fetch_strobe,
    output logic                halted,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    localparam logic [SIZE_CNT:0] CMAX  = CNT_MAX[SIZE_CNT:0];
    localparam logic [SIZE_CNT:0] CFET  = CNT_CLK[SIZE_CNT:0];
    localparam logic [3:0]        LAST  = LAST_ADDR[3:0];
    state_t            state_q, state_d;
    logic [SIZE_CNT:0] cnt_q, cnt_d;
    logic [3:0]        addr_q, addr_d, addr_inc, jmp_legal;
    logic              hlt_q, hlt_d, boundary, auto_halt;
    assign boundary  = (state_q == RUN) && !stall && (cnt_q == CMAX);
    assign addr_inc  = (addr_q >= LAST) ? 4'd1 : addr_q + 4'd1;
    assign jmp_legal = (jmp_addr == 4'd0 || jmp_addr > LAST) ? 4'd1 : jmp_addr;
`ifdef PC_SEQ_AUTOHALT_EN
    assign auto_halt = boundary && !jmp_en && (addr_q == LAST);
`else
    assign auto_halt = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        hlt_d   = hlt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = run ? RUN : IDLE;
            end
            RUN: begin
                // a request during a stalled cycle still latches
                hlt_d = hlt_q | halt_req;
                if (!stall) begin
                    cnt_d = boundary ? '0 : cnt_q + 1'b1;
                    if (boundary) begin
                        addr_d  = jmp_en ? jmp_legal : addr_inc;
                        state_d = (hlt_d || auto_halt) ? HALT : RUN;
                        hlt_d   = 1'b0;
                    end
                end
            end
            HALT: begin
                cnt_d   = '0;
                state_d = (run && !halt_req) ? RUN : HALT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 4'd1;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hlt_q   <= hlt_d;
        end
    end
    assign cnt_clk      = cnt_q;
    assign Data_Addr    = addr_q;
    assign fetch_strobe = (state_q == RUN) && (cnt_q == CFET) && !stall;
    assign busy         = (state_q == RUN);
    assign halted       = (state_q == HALT);
endmodule
